// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: wide addition performed one nibble at a time on an
// external 4-bit ripple-carry slice. Operands latch on start. Nibbles go to the
// slice least significant first, and each is held SETTLE cycles before its sum
// and carry are captured. The full sum and carry-out appear with a done pulse.
module nibble_add_sequencer #(
    parameter int NIBBLES = 4,
    parameter int SETTLE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_reg, b_reg, partial, partial_upd;
    logic            cin_reg, carry_reg;
    logic            last_cnt, last_idx;

    // End-of-settle / last-nibble flags and the partial sum with the slice
    // output merged in, so the final capture can load result in the same edge.
    always_comb begin
        last_cnt                 = (cnt == CW'(SETTLE - 1));
        last_idx                 = (idx == IW'(NIBBLES - 1));
        partial_upd              = partial;
        partial_upd[4*idx +: 4]  = add_sum;
    end

    // Next-state logic and decoded outputs (slice inputs are zero outside RUN).
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_reg[4*idx +: 4];
                add_b   = b_reg[4*idx +: 4];
                add_cin = (idx == '0) ? cin_reg : carry_reg;
                if (last_cnt && last_idx) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand latches, nibble/settle counters, carry chain and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            partial   <= '0;
            result    <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        cin_reg <= cin;
                        idx     <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    if (last_cnt) begin
                        partial   <= partial_upd;
                        carry_reg <= add_cout;
                        cnt       <= '0;
                        idx       <= last_idx ? '0 : idx + 1'b1;
                        if (last_idx) begin
                            result <= partial_upd;
                            cout   <= add_cout;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench for nibble_add_sequencer: accepted operations push their
// expected sum; a monitor pops on done and checks busy/done timing and the
// nibble presented to the slice each cycle.
module tb_nibble_add_sequencer;

    localparam int N = 4;
    localparam int S = 1;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst, start, cin;
    logic [W-1:0]  op_a, op_b, result;
    logic          busy, done, cout;
    logic [3:0]    add_a, add_b, add_sum;
    logic          add_cin, add_cout;

    logic          start3;
    logic [W-1:0]  op_a3, op_b3, result3;
    logic          busy3, done3, cout3, add_cin3, add_cout3;
    logic [3:0]    add_a3, add_b3, add_sum3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Ideal 4-bit ripple slices.
    assign {add_cout, add_sum}   = add_a + add_b + 5'(add_cin);
    assign {add_cout3, add_sum3} = add_a3 + add_b3 + 5'(add_cin3);

    nibble_add_sequencer #(.NIBBLES(N), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    nibble_add_sequencer #(.NIBBLES(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .op_a(op_a3), .op_b(op_b3), .cin(1'b0),
        .busy(busy3), .done(done3), .result(result3), .cout(cout3),
        .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_sum(add_sum3), .add_cout(add_cout3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model state: one operation in flight at most.
    int          cyc = 0;
    int          acc = 0;
    bit          have_op = 0;
    logic [63:0] cur_a, cur_b;
    logic        cur_cin;
    logic [16:0] exp_q[$];
    int          ndone = 0;

    function automatic bit model_busy(input int q);
        return have_op && q >= acc + 1 && q <= acc + N*S + 1;
    endfunction

    // Acceptance: a start seen while the model says the block is idle launches
    // a new operation and queues its arithmetic result.
    always @(posedge clk) begin
        if (!rst && start && !model_busy(cyc)) begin
            have_op = 1;
            acc     = cyc;
            cur_a   = 64'(op_a);
            cur_b   = 64'(op_b);
            cur_cin = cin;
            exp_q.push_back(17'(op_a) + 17'(op_b) + 17'(cin));
        end
        cyc = cyc + 1;
    end

    // Monitor: timing, slice drive and result checks each cycle.
    always @(negedge clk) begin
        int          k;
        logic [63:0] m, ea, eb, ec;
        logic [16:0] e;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_cout", cout, 0);
            chk("rst_add", {add_a, add_b, add_cin}, 0);
        end else begin
            chk("busy", busy, model_busy(cyc));
            chk("done", done, have_op && cyc == acc + N*S + 1);
            ea = 0; eb = 0; ec = 0;
            if (have_op && cyc >= acc + 1 && cyc <= acc + N*S) begin
                k  = (cyc - acc - 1) / S;
                m  = (64'd1 << (4*k)) - 1;
                ea = (cur_a >> (4*k)) & 64'hF;
                eb = (cur_b >> (4*k)) & 64'hF;
                ec = (k == 0) ? 64'(cur_cin)
                              : (((cur_a & m) + (cur_b & m) + 64'(cur_cin)) >> (4*k)) & 64'd1;
            end
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
            chk("add_cin", add_cin, ec);
            if (done) begin
                ndone++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected at t=%0t: got done=1 expected no pending op", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e[15:0]);
                    chk("cout", cout, e[16]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        step();
        start = 1'b0;
    endtask

    initial begin
        int d0, dq;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start3 = 1'b0; op_a3 = '0; op_b3 = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Wrap-around and nibble ordering.
        issue(16'hFFFF, 16'h0001, 1'b0);
        repeat (6) step();
        issue(16'h1234, 16'h4321, 1'b1);
        repeat (6) step();

        // Starts during RUN (cycle 2) and DONE (cycle 5) are ignored.
        issue(16'hA5A5, 16'h1111, 1'b0);      // now in cycle 1
        step();                                // cycle 2
        start = 1'b1; op_a = 16'h0F0F; op_b = 16'h7777; cin = 1'b1;
        step();                                // cycle 3
        start = 1'b0; op_a = 16'h0;
        repeat (2) step();                     // cycle 5
        start = 1'b1; op_a = 16'hBEEF; op_b = 16'h1234;
        step();                                // cycle 6
        start = 1'b0;
        repeat (3) step();

        // Asynchronous reset mid-operation.
        issue(16'h8001, 16'h8001, 1'b1);      // cycle 1
        repeat (2) step();                     // cycle 3
        rst = 1'b1;
        have_op = 0;
        exp_q.delete();
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_add_a", add_a, 0);
        chk("arst_add_b", add_b, 0);
        step();
        rst = 1'b0;
        issue(16'h7FFF, 16'h0001, 1'b1);
        repeat (8) step();

        // Back-to-back with start held high and random operands.
        d0 = ndone;
        start = 1'b1;
        for (int i = 0; i < 50*(N*S+2); i++) begin
            op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
            step();
        end
        start = 1'b0;
        repeat (4) step();
        chk("b2b_done_count", ndone - d0, 50);

        // SETTLE=3 instance: each nibble held 3 cycles, done in cycle 13.
        start3 = 1'b1; op_a3 = 16'h00FF; op_b3 = 16'h0F01;
        dq = -1;
        for (int q = 1; q <= 20 && dq < 0; q++) begin
            step();
            start3 = 1'b0;
            op_a3 = 16'h5555; op_b3 = 16'hAAAA;
            @(negedge clk);
            if (q <= 12) begin
                chk("s3_add_a", add_a3, (16'h00FF >> (4*((q-1)/3))) & 16'hF);
                chk("s3_add_b", add_b3, (16'h0F01 >> (4*((q-1)/3))) & 16'hF);
            end
            if (done3) begin
                dq = q;
                chk("s3_result", result3, 16'h1000);
                chk("s3_cout", cout3, 0);
            end
        end
        chk("s3_done_cycle", dq, 13);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle controller that computes a (4·NIBBLES)-bit addition using one external 4-bit ripple-carry adder slice. It latches a pair of wide operands on a start pulse and presents them to the slice one nibble at a time, least significant nibble first. It chains each captured carry into the next nibble and returns the full sum and carry-out with a one-cycle done pulse. A programmable settle interval per nibble covers the slice's propagation delay. The block sits between an operand source and the shared 4-bit adder slice, and owns all sequencing of that slice.

## Interface
Parameters:
- NIBBLES, 4: number of nibbles per operand; operand width W = 4·NIBBLES. Legal range ≥ 2.
- SETTLE, 1: clock cycles each nibble is held on the slice before capture. Legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; latched when start is accepted.
- op_b  in  W  operand B; latched when start is accepted.
- cin  in  1  carry-in; latched when start is accepted.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and cout are valid from this cycle.
- result  out  W  sum register.
- cout  out  1  final carry-out register.
- add_a  out  4  nibble of A driven to the slice.
- add_b  out  4  nibble of B driven to the slice.
- add_cin  out  1  carry driven into the slice.
- add_sum  in  4  slice sum (combinational from the add_* outputs).
- add_cout  in  1  slice carry-out.

## Operation
States: IDLE, RUN, DONE.
- Reset (rst high, any time, including mid-operation):
  - State goes to IDLE; nibble index idx and settle counter cnt go to 0.
  - All internal operand, carry and partial-sum registers clear to 0.
  - Outputs: busy=0, done=0, result=0, cout=0, add_a=0, add_b=0, add_cin=0.
- IDLE:
  - add_* outputs are driven to 0.
  - start=1 at a clock edge latches op_a, op_b and cin, sets idx=0 and cnt=0, and moves to RUN.
- RUN:
  - add_a = A_reg[4·idx+3:4·idx] and add_b = B_reg[4·idx+3:4·idx].
  - add_cin = cin_reg when idx=0; otherwise add_cin = carry_reg.
  - When cnt < SETTLE-1: cnt increments.
  - When cnt = SETTLE-1, at that edge:
    - partial[4·idx+3:4·idx] ← add_sum and carry_reg ← add_cout;
    - cnt ← 0 and idx ← idx+1;
    - if idx was NIBBLES-1, go to DONE, with result ← full partial (including this nibble) and cout ← add_cout.
- DONE: done=1 for exactly one cycle, then go to IDLE. add_* outputs are driven to 0.
- start is ignored in RUN and DONE. The operand latches change only when a start is accepted, so op_a, op_b and cin may change freely while busy.
- result and cout change only on the RUN→DONE edge or on reset, and hold otherwise. They show no intermediate nibble values.
- Arithmetic: {cout, result} = op_a + op_b + cin, modulo 2^(W+1). Wrap-around is expected, e.g. all-ones + 1 gives 0 with cout=1.

## Timing
- Take the cycle in which start is sampled high in IDLE as cycle 0.
- RUN occupies cycles 1 to NIBBLES·SETTLE. Nibble k is on add_* during cycles 1+k·SETTLE to (k+1)·SETTLE, and is captured at the end of the last of those cycles.
- done is high in cycle NIBBLES·SETTLE+1 (cycle 5 with defaults). busy is high in cycles 1 to NIBBLES·SETTLE+1.
- The earliest next accepted start is in cycle NIBBLES·SETTLE+2. If start is held high continuously, a new operation begins every NIBBLES·SETTLE+2 cycles.
- The slice path (add_* → add_sum/add_cout) must settle within SETTLE clock periods. The block does no pipelining across nibbles.
- rst is asynchronous: outputs go to their reset values without waiting for a clock edge. The first start can be accepted at the first rising edge after rst deasserts.

## Test plan
- Defaults, op_a=0xFFFF, op_b=0x0001, cin=0 → done in cycle 5, result=0x0000, cout=1. add_cin must be 1 in cycles 2, 3 and 4.
- Defaults, op_a=0x1234, op_b=0x4321, cin=1 → result=0x5556, cout=0. add_a/add_b must show nibbles 4/1, 3/2, 2/3, 1/4 in cycles 1 to 4.
- SETTLE=3, op_a=0x00FF, op_b=0x0F01, cin=0 → each nibble is held 3 cycles, done in cycle 13, result=0x1000, cout=0.
- Defaults, a second start pulse with different operands is issued in cycles 2 and 5 → both are ignored. The first result stands, and busy/done timing is unchanged.
- Defaults, rst asserted in cycle 3 of an operation → busy, done, result, cout and add_* go to 0 immediately. No done pulse follows. A new start after reset release gives a correct sum in cycle 5.
- Defaults, start held high with random operands for 50 operations → done every 6 cycles, and each result and cout matches op_a + op_b + cin.
